// File: rtl/chunked_seq_adder.sv
// Multi-cycle adder: sums two WIDTH-bit operands plus carry-in, CHUNK bits per clock,
// behind a start/busy/done handshake. Sum, carry-out and signed overflow are all registered.
module chunked_seq_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCH = WIDTH / CHUNK;
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [CHUNK:0]   w_chunk;
  logic [CHUNK-1:0] w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_ovf;

  // Operands shift right each cycle so the active chunk always sits in the low bits.
  assign w_chunk   = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
  assign w_sum     = w_chunk[CHUNK-1:0];
  assign w_carry   = w_chunk[CHUNK];
  assign w_acc_nxt = (r_acc >> CHUNK) | (WIDTH'(w_sum) << (WIDTH - CHUNK));
  assign w_ovf     = (r_a[CHUNK-1] == r_b[CHUNK-1]) && (w_sum[CHUNK-1] != r_a[CHUNK-1]);
  assign w_last    = (r_cnt == CW'(NCH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= w_busy_nxt;
      done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_accept    = 1'b1;
        end
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == S_RUN);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // Datapath: capture on accept, one chunk per RUN cycle, publish results on the last chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      out     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (w_accept) begin
      r_a     <= in1;
      r_b     <= in2;
      r_acc   <= '0;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> CHUNK;
      r_b     <= r_b >> CHUNK;
      r_acc   <= w_acc_nxt;
      r_carry <= w_carry;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        out  <= w_acc_nxt;
        cout <= w_carry;
        ovf  <= w_ovf;
      end
    end
  end

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Scoreboard bench for chunked_seq_adder: three instances (CHUNK=4, 1, 16) driven by
// directed vectors; a negedge monitor pops expected results whenever done is seen.
module tb_chunked_seq_adder;

  typedef struct {
    logic [15:0] out;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start_v = 3'b000;
  logic [15:0] in1 = 16'h0;
  logic [15:0] in2 = 16'h0;
  logic        cin = 1'b0;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [2:0]  cout_v;
  logic [2:0]  ovf_v;
  logic [15:0] out_v [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in1(in1), .in2(in2), .cin(cin),
    .busy(busy_v[0]), .done(done_v[0]), .out(out_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));
  chunked_seq_adder #(.WIDTH(16), .CHUNK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in1(in1), .in2(in2), .cin(cin),
    .busy(busy_v[1]), .done(done_v[1]), .out(out_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));
  chunked_seq_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .in1(in1), .in2(in2), .cin(cin),
    .busy(busy_v[2]), .done(done_v[2]), .out(out_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));

  function automatic int nch(input int sel);
    case (sel)
      0: return 4;
      1: return 16;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int sel, input logic [15:0] o, input logic c, input logic v,
                      input int acc);
    exp_t e;
    e.out = o; e.cout = c; e.ovf = v; e.acc = acc;
    case (sel)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Monitor: pop and compare on every done pulse; busy and done must never overlap.
  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("busy_done_excl[%0d]", s), 32'(busy_v[s] & done_v[s]), 32'd0);
      if (rst_n && done_v[s]) begin
        exp_t e;
        int   n;
        case (s)
          0: n = q0.size();
          1: n = q1.size();
          default: n = q2.size();
        endcase
        if (n == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done[%0d]: got done=1 expected no pending op", s);
        end else begin
          case (s)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
          endcase
          chk($sformatf("out[%0d]", s), 32'(out_v[s]), 32'(e.out));
          chk($sformatf("cout[%0d]", s), 32'(cout_v[s]), 32'(e.cout));
          chk($sformatf("ovf[%0d]", s), 32'(ovf_v[s]), 32'(e.ovf));
          chk($sformatf("latency[%0d]", s), 32'(cyc - e.acc), 32'(nch(s)));
        end
      end
    end
  end

  // Wait (bounded) for done on one instance, counting busy cycles on the way.
  task automatic wait_done(input int sel, output int busy_cnt);
    int n = 0;
    busy_cnt = 0;
    while (!done_v[sel] && n < 64) begin
      if (busy_v[sel]) busy_cnt++;
      @(negedge clk);
      n++;
    end
    if (!done_v[sel]) begin
      checks++;
      errors++;
      $display("FAIL done_timeout[%0d]: got no done expected done within 64 cycles", sel);
    end
  endtask

  task automatic op(input int sel, input logic [15:0] a, input logic [15:0] b, input logic c,
                    input logic [15:0] eo, input logic ec, input logic ev);
    int bc;
    @(negedge clk);
    in1 = a; in2 = b; cin = c;
    start_v[sel] = 1'b1;
    push(sel, eo, ec, ev, cyc + 1);
    @(negedge clk);
    start_v[sel] = 1'b0;
    in1 = ~a; in2 = ~b; cin = ~c;
    wait_done(sel, bc);
    chk($sformatf("busy_cycles[%0d]", sel), 32'(bc), 32'(nch(sel)));
  endtask

  initial begin
    int bc;
    start_v = 3'b111;
    in1 = 16'hFFFF; in2 = 16'hFFFF; cin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
        chk($sformatf("rst_busy[%0d]", s), 32'(busy_v[s]), 32'd0);
        chk($sformatf("rst_done[%0d]", s), 32'(done_v[s]), 32'd0);
        chk($sformatf("rst_out[%0d]", s), 32'(out_v[s]), 32'd0);
        chk($sformatf("rst_cout_ovf[%0d]", s), 32'({cout_v[s], ovf_v[s]}), 32'd0);
      end
    end
    start_v = 3'b000;
    rst_n = 1'b1;
    @(negedge clk);

    op(0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    op(0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op(0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    op(0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
    op(0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Operands change and start pulses during RUN must not disturb the captured operation.
    @(negedge clk);
    in1 = 16'h0F0F; in2 = 16'h0101; cin = 1'b0; start_v[0] = 1'b1;
    push(0, 16'h1010, 1'b0, 1'b0, cyc + 1);
    @(negedge clk);
    start_v[0] = 1'b0; in1 = 16'hAAAA; in2 = 16'h5555; cin = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, bc);

    // Back-to-back: start held through DONE, second operands accepted in DONE.
    @(negedge clk);
    in1 = 16'h1111; in2 = 16'h2222; cin = 1'b0; start_v[0] = 1'b1;
    push(0, 16'h3333, 1'b0, 1'b0, cyc + 1);
    push(0, 16'h0003, 1'b0, 1'b0, cyc + 6);
    @(negedge clk);
    in1 = 16'h0001; in2 = 16'h0002;
    wait_done(0, bc);
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("b2b_busy_reassert", 32'(busy_v[0]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_out_hold", 32'(out_v[0]), 32'h3333);
      @(negedge clk);
    end
    wait_done(0, bc);

    // Reset after two committed chunks discards the operation.
    @(negedge clk);
    in1 = 16'hFFFF; in2 = 16'h0001; cin = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy_v[0]), 32'd0);
    chk("mid_rst_done", 32'(done_v[0]), 32'd0);
    chk("mid_rst_out", 32'(out_v[0]), 32'd0);
    chk("mid_rst_cout_ovf", 32'({cout_v[0], ovf_v[0]}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 32'({busy_v[0], done_v[0]}), 32'd0);
    end
    op(0, 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0);

    op(1, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    op(1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op(1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    op(2, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    op(2, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op(2, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    chk("queues_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
